// File: rtl/ascon_block_sequencer_if.sv
// Core-side bus between the block sequencer and the Ascon AEAD core.
// master = sequencer, slave = core.
interface ascon_block_sequencer_if #(
    parameter int pBLOCK_WIDTH = 128,
    parameter int pVB_WIDTH    = 5
);
    logic                    O_core_start;
    logic                    O_core_valid;
    logic [pBLOCK_WIDTH-1:0] O_core_data;
    logic [pVB_WIDTH-1:0]    O_core_bytes;
    logic                    O_core_last;
    logic                    O_core_eot;
    logic                    O_core_select;
    logic                    I_core_rfd;
    logic                    I_core_read;
    logic                    I_core_ct_valid;
    logic [pBLOCK_WIDTH-1:0] I_core_ct;
    logic                    I_core_tag_valid;
    logic [127:0]            I_core_tag;

    modport master (
        output O_core_start, O_core_valid, O_core_data,
        output O_core_bytes, O_core_last, O_core_eot,
        output O_core_select,
        input  I_core_rfd, I_core_read, I_core_ct_valid,
        input  I_core_ct, I_core_tag_valid, I_core_tag
    );

    modport slave (
        input  O_core_start, O_core_valid, O_core_data,
        input  O_core_bytes, O_core_last, O_core_eot,
        input  O_core_select,
        output I_core_rfd, I_core_read, I_core_ct_valid,
        output I_core_ct, I_core_tag_valid, I_core_tag
    );
endinterface

// File: rtl/ascon_block_sequencer.sv
// Streams queued AD/message blocks into the Ascon core, collects ciphertext and tag.
// Optional cycle counter: define ASCON_SEQ_CYCLE_COUNT_EN.
module ascon_block_sequencer #(
    parameter int pBLOCK_WIDTH = 128,
    parameter int pDEPTH       = 8,
    parameter int pVB_WIDTH    = 5,
    parameter int pCNT_WIDTH   = 32
) (
    input  logic                    crypto_clk,
    input  logic                    reset_i,
    input  logic                    I_start,
    input  logic                    I_in_valid,
    input  logic [pBLOCK_WIDTH-1:0] I_in_data,
    input  logic [pVB_WIDTH-1:0]    I_in_bytes,
    input  logic                    I_in_is_msg,
    input  logic                    I_in_last,
    output logic                    O_in_ready,
    output logic                    O_ct_valid,
    output logic [pBLOCK_WIDTH-1:0] O_ct_data,
    input  logic                    I_ct_ready,
    output logic [127:0]            O_tag,
    output logic                    O_tag_valid,
    output logic                    O_busy,
    output logic                    O_done,
    output logic                    O_error,
`ifdef ASCON_SEQ_CYCLE_COUNT_EN
    output logic [pCNT_WIDTH-1:0]   O_cycles,
`endif
    ascon_block_sequencer_if.master core
);

    localparam int AW = $clog2(pDEPTH);
    localparam int CW = AW + 1;
    localparam int EW = pBLOCK_WIDTH + pVB_WIDTH + 2;

    if (pDEPTH < 2 || (pDEPTH & (pDEPTH - 1)) != 0) begin : g_bad_depth
        $error("pDEPTH must be a power of two >= 2");
    end
    if ((1 << pVB_WIDTH) <= pBLOCK_WIDTH / 8) begin : g_bad_vb
        $error("pVB_WIDTH too narrow");
    end
    if (pCNT_WIDTH < 1) begin : g_bad_cnt
        $error("pCNT_WIDTH must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_FEED, S_WAIT_TAG, S_DONE, S_ERROR
    } state_e;

    state_e state_q, state_d;

    logic [EW-1:0] in_mem_q [pDEPTH];
    logic [AW-1:0] in_wp_q, in_rp_q;
    logic [CW-1:0] in_cnt_q;

    logic [pBLOCK_WIDTH-1:0] ct_mem_q [pDEPTH];
    logic [AW-1:0] ct_wp_q, ct_rp_q;
    logic [CW-1:0] ct_cnt_q;

    logic msg_seen_q, ad_last_q;
    logic tag_valid_q, error_q;
    logic [127:0] tag_q;

    logic [EW-1:0]           head;
    logic [pBLOCK_WIDTH-1:0] head_data;
    logic [pVB_WIDTH-1:0]    head_bytes;
    logic                    head_msg, head_last;
    logic in_empty, in_full, in_push, in_pop;
    logic ct_empty, ct_full, ct_push, ct_pop, ct_clr;
    logic head_valid, seq_err, space_ok, feed, start_acc;

    assign head       = in_mem_q[in_rp_q];
    assign head_last  = head[0];
    assign head_msg   = head[1];
    assign head_bytes = head[2 +: pVB_WIDTH];
    assign head_data  = head[2+pVB_WIDTH +: pBLOCK_WIDTH];

    assign in_empty = (in_cnt_q == '0);
    assign in_full  = (in_cnt_q == CW'(pDEPTH));
    assign ct_empty = (ct_cnt_q == '0);
    assign ct_full  = (ct_cnt_q == CW'(pDEPTH));

    assign start_acc  = (state_q == S_IDLE) && I_start;
    assign head_valid = (state_q == S_FEED) && !in_empty;
    // AD after message data, or a second closing AD block, is a host error
    assign seq_err  = head_valid && !head_msg &&
                      (msg_seen_q || (head_last && ad_last_q));
    assign space_ok = !head_msg || !ct_full;
    assign feed     = head_valid && core.I_core_rfd && space_ok && !seq_err;

    assign in_push = I_in_valid && !in_full && (state_q != S_ERROR);
    assign in_pop  = feed && core.I_core_read;

    assign ct_pop  = I_ct_ready && !ct_empty;
    assign ct_clr  = start_acc;
    assign ct_push = core.I_core_ct_valid &&
                     (state_q != S_IDLE) && (state_q != S_ERROR) &&
                     (!ct_full || ct_pop);

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (I_start) state_d = S_START;
            S_START:    state_d = S_FEED;
            S_FEED: begin
                if (seq_err) begin
                    state_d = S_ERROR;
                end else if (in_pop && head_msg && head_last) begin
                    state_d = S_WAIT_TAG;
                end
            end
            S_WAIT_TAG: if (core.I_core_tag_valid) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            S_ERROR:    if (I_start) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        core.O_core_start  = (state_q == S_START);
        core.O_core_valid  = feed;
        core.O_core_data   = head_valid ? head_data : '0;
        core.O_core_bytes  = head_valid ? head_bytes : '0;
        core.O_core_last   = head_valid && head_last;
        core.O_core_select = head_valid && head_msg;
        core.O_core_eot    = head_valid && head_msg && head_last;
        O_busy             = (state_q != S_IDLE);
        O_done             = (state_q == S_DONE);
    end

    assign O_in_ready  = !in_full;
    assign O_ct_valid  = !ct_empty;
    assign O_ct_data   = ct_empty ? '0 : ct_mem_q[ct_rp_q];
    assign O_tag       = tag_q;
    assign O_tag_valid = tag_valid_q;
    assign O_error     = error_q;

    always_ff @(posedge crypto_clk) begin
        if (in_push) begin
            in_mem_q[in_wp_q] <= {I_in_data, I_in_bytes, I_in_is_msg, I_in_last};
        end
        if (ct_push) begin
            ct_mem_q[ct_wp_q] <= core.I_core_ct;
        end
    end

    always_ff @(posedge crypto_clk) begin
        if (reset_i || state_q == S_ERROR) begin
            in_wp_q  <= '0;
            in_rp_q  <= '0;
            in_cnt_q <= '0;
        end else begin
            if (in_push) in_wp_q <= in_wp_q + 1'b1;
            if (in_pop)  in_rp_q <= in_rp_q + 1'b1;
            in_cnt_q <= in_cnt_q + CW'(in_push) - CW'(in_pop);
        end
    end

    always_ff @(posedge crypto_clk) begin
        if (reset_i || ct_clr) begin
            ct_wp_q  <= '0;
            ct_rp_q  <= '0;
            ct_cnt_q <= '0;
        end else begin
            if (ct_push) ct_wp_q <= ct_wp_q + 1'b1;
            if (ct_pop)  ct_rp_q <= ct_rp_q + 1'b1;
            ct_cnt_q <= ct_cnt_q + CW'(ct_push) - CW'(ct_pop);
        end
    end

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            msg_seen_q  <= 1'b0;
            ad_last_q   <= 1'b0;
            tag_valid_q <= 1'b0;
            tag_q       <= '0;
            error_q     <= 1'b0;
        end else begin
            if (start_acc) begin
                msg_seen_q  <= 1'b0;
                ad_last_q   <= 1'b0;
                tag_valid_q <= 1'b0;
                error_q     <= 1'b0;
            end else begin
                if (in_pop && head_msg)               msg_seen_q <= 1'b1;
                if (in_pop && !head_msg && head_last) ad_last_q  <= 1'b1;
                if (seq_err)                          error_q    <= 1'b1;
                if (state_q == S_WAIT_TAG && core.I_core_tag_valid) begin
                    tag_q       <= core.I_core_tag;
                    tag_valid_q <= 1'b1;
                end
            end
        end
    end

`ifdef ASCON_SEQ_CYCLE_COUNT_EN
    logic [pCNT_WIDTH-1:0] cyc_q;

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            cyc_q <= '0;
        end else if (state_q == S_START) begin
            cyc_q <= pCNT_WIDTH'(1);
        end else if ((state_q == S_FEED || state_q == S_WAIT_TAG ||
                      state_q == S_DONE) && cyc_q != '1) begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    assign O_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_ascon_block_sequencer.sv
// Directed bench for ascon_block_sequencer with a simple always-ready core model.
// Core model: ct = data ^ A5.., tag a fixed constant three cycles after EOT.
module tb_ascon_block_sequencer;
    localparam int BW   = 128;
    localparam int DEP  = 8;
    localparam int VBW  = 5;
    localparam int CNTW = 32;

    localparam logic [127:0] CTX  = {16{8'hA5}};
    localparam logic [127:0] TAGK = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           I_start, I_in_valid, I_in_is_msg, I_in_last;
    logic [BW-1:0]  I_in_data;
    logic [VBW-1:0] I_in_bytes;
    logic           O_in_ready, O_ct_valid, I_ct_ready;
    logic [BW-1:0]  O_ct_data;
    logic [127:0]   O_tag;
    logic           O_tag_valid, O_busy, O_done, O_error;
`ifdef ASCON_SEQ_CYCLE_COUNT_EN
    logic [CNTW-1:0] O_cycles;
`endif

    ascon_block_sequencer_if #(.pBLOCK_WIDTH(BW), .pVB_WIDTH(VBW)) cif();

    ascon_block_sequencer #(
        .pBLOCK_WIDTH(BW), .pDEPTH(DEP), .pVB_WIDTH(VBW), .pCNT_WIDTH(CNTW)
    ) dut (
        .crypto_clk (clk),
        .reset_i    (rst),
        .I_start    (I_start),
        .I_in_valid (I_in_valid),
        .I_in_data  (I_in_data),
        .I_in_bytes (I_in_bytes),
        .I_in_is_msg(I_in_is_msg),
        .I_in_last  (I_in_last),
        .O_in_ready (O_in_ready),
        .O_ct_valid (O_ct_valid),
        .O_ct_data  (O_ct_data),
        .I_ct_ready (I_ct_ready),
        .O_tag      (O_tag),
        .O_tag_valid(O_tag_valid),
        .O_busy     (O_busy),
        .O_done     (O_done),
        .O_error    (O_error),
`ifdef ASCON_SEQ_CYCLE_COUNT_EN
        .O_cycles   (O_cycles),
`endif
        .core       (cif.master)
    );

    logic       rfd_en;
    logic [1:0] tag_cnt;

    assign cif.I_core_rfd       = rfd_en;
    assign cif.I_core_read      = cif.O_core_valid;
    assign cif.I_core_ct_valid  = cif.O_core_valid && cif.O_core_select &&
                                  (cif.O_core_bytes != '0);
    assign cif.I_core_ct        = cif.O_core_data ^ CTX;
    assign cif.I_core_tag_valid = (tag_cnt == 2'd1);
    assign cif.I_core_tag       = TAGK;

    always @(posedge clk) begin
        if (rst) tag_cnt <= '0;
        else if (cif.O_core_valid && cif.O_core_eot) tag_cnt <= 2'd3;
        else if (tag_cnt != '0) tag_cnt <= tag_cnt - 2'd1;
    end

    logic [127:0] ct_q[$];
    int n_done = 0;
    int n_read = 0;
    int meas = 0;
    bit meas_on = 1'b0;

    always @(negedge clk) begin
        if (O_ct_valid && I_ct_ready) ct_q.push_back(O_ct_data);
        if (cif.O_core_valid && cif.I_core_read) n_read++;
        if (O_done) n_done++;
        if (cif.O_core_start) begin
            meas = 1;
            meas_on = 1'b1;
        end else if (meas_on) begin
            meas++;
            if (O_done) meas_on = 1'b0;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] blk(input int i);
        return {4{32'hC0DE0000 + i}};
    endfunction

    task automatic push(input logic [127:0] d, input int b,
                        input bit m, input bit l);
        int w = 0;
        @(negedge clk);
        I_in_valid  = 1'b1;
        I_in_data   = d;
        I_in_bytes  = VBW'(b);
        I_in_is_msg = m;
        I_in_last   = l;
        while (!O_in_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (!O_in_ready) check("push_timeout", O_in_ready, 1);
        @(negedge clk);
        I_in_valid = 1'b0;
    endtask

    task automatic start();
        @(negedge clk);
        I_start = 1'b1;
        @(negedge clk);
        I_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int w = 0;
        while (!O_done && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (!O_done) check(tag, O_done, 1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"}, O_in_ready, 1);
        check({tag, "_flags"},
              {O_busy, O_ct_valid, O_tag_valid, O_error, O_done,
               cif.O_core_valid, cif.O_core_start, cif.O_core_eot}, 0);
        check({tag, "_tag"}, O_tag, 0);
        check({tag, "_cdata"}, cif.O_core_data, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int base_ct, base_rd, base_dn, w;

    initial begin
        rst = 1'b1;
        I_start = 1'b0;
        I_in_valid = 1'b0;
        I_in_data = '0;
        I_in_bytes = '0;
        I_in_is_msg = 1'b0;
        I_in_last = 1'b0;
        I_ct_ready = 1'b1;
        rfd_en = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst = 1'b0;

        // 2 AD + 3 message blocks
        base_ct = ct_q.size();
        base_dn = n_done;
        push(blk(1), 16, 0, 0);
        push(blk(2), 16, 0, 1);
        push(blk(3), 16, 1, 0);
        push(blk(4), 16, 1, 0);
        push(blk(5), 5, 1, 1);
        start();
        check("t1_core_start", cif.O_core_start, 1);
        @(negedge clk);
        check("t1_first", {cif.O_core_valid, cif.O_core_select,
                           cif.O_core_last, cif.O_core_eot}, 4'b1000);
        check("t1_first_data", cif.O_core_data, blk(1));
        wait_done("t1_done_timeout");
        check("t1_tag_valid", O_tag_valid, 1);
        check("t1_tag", O_tag, TAGK);
        repeat (4) @(negedge clk);
        check("t1_done_pulses", n_done - base_dn, 1);
        check("t1_error", O_error, 0);
        check("t1_idle", O_busy, 0);
        check("t1_ct_count", ct_q.size() - base_ct, 3);
        for (int k = 0; k < 3; k++)
            check($sformatf("t1_ct%0d", k), ct_q[base_ct+k], blk(3+k) ^ CTX);

        // ciphertext back-pressure with a 10-block message
        I_ct_ready = 1'b0;
        base_ct = ct_q.size();
        base_rd = n_read;
        for (int i = 0; i < 8; i++) push(blk(10+i), 16, 1, 0);
        start();
        push(blk(18), 16, 1, 0);
        push(blk(19), 16, 1, 1);
        repeat (20) @(negedge clk);
        check("t2_fed", n_read - base_rd, 8);
        check("t2_valid_held", cif.O_core_valid, 0);
        check("t2_ct_valid", O_ct_valid, 1);
        check("t2_ct_none", ct_q.size() - base_ct, 0);
        start();
        check("t2_busy_start", {O_busy, cif.O_core_start}, 2'b10);
        I_ct_ready = 1'b1;
        wait_done("t2_done_timeout");
        repeat (4) @(negedge clk);
        check("t2_ct_count", ct_q.size() - base_ct, 10);
        for (int k = 0; k < 10; k++)
            check($sformatf("t2_ct%0d", k), ct_q[base_ct+k], blk(10+k) ^ CTX);

        // AD after message data
        push(blk(30), 16, 1, 0);
        push(blk(31), 16, 0, 1);
        start();
        w = 0;
        while (!O_error && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("t3_error", O_error, 1);
        check("t3_in_error", {O_busy, cif.O_core_valid}, 2'b10);
        start();
        check("t3_exit_idle", {O_busy, cif.O_core_start}, 0);
        check("t3_err_sticky", O_error, 1);

        // empty AD + empty message; head also shows the flush
        push(blk(32), 0, 1, 1);
        base_ct = ct_q.size();
        start();
        check("t4_core_start", cif.O_core_start, 1);
        check("t4_err_clr", O_error, 0);
        @(negedge clk);
        check("t4_eot", {cif.O_core_valid, cif.O_core_eot,
                         cif.O_core_select}, 3'b111);
        check("t4_head", cif.O_core_data, blk(32));
        wait_done("t4_done_timeout");
        check("t4_tag", {O_tag_valid, O_tag}, {1'b1, TAGK});
        repeat (4) @(negedge clk);
        check("t4_ct_none", ct_q.size() - base_ct, 0);

        // full input FIFO, push refused while popping, then reset in FEED
        for (int i = 0; i < 8; i++) push(blk(40+i), 16, 1, i == 7);
        check("t5_full", O_in_ready, 0);
        start();
        @(negedge clk);
        check("t5_pop_now", cif.O_core_valid, 1);
        I_in_valid = 1'b1;
        I_in_data  = blk(99);
        I_in_bytes = 5'd16;
        I_in_is_msg = 1'b1;
        I_in_last = 1'b0;
        @(negedge clk);
        I_in_valid = 1'b0;
        rfd_en = 1'b0;
        check("t5_refused", O_in_ready, 1);
        @(negedge clk);
        check("t5_hold7", {O_in_ready, cif.O_core_valid, O_busy}, 3'b101);
        rst = 1'b1;
        @(negedge clk);
        check_reset("t5_rst");
        rst = 1'b0;
        rfd_en = 1'b1;

`ifdef ASCON_SEQ_CYCLE_COUNT_EN
        push(blk(50), 16, 0, 1);
        push(blk(51), 16, 1, 1);
        start();
        wait_done("t6_done_timeout");
        repeat (2) @(negedge clk);
        check("t6_cycles_meas", O_cycles, meas);
        check("t6_cycles_hand", O_cycles, 7);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
